// File: rtl/reservation_station.sv
// reservation_station: holds ALU-bound instructions until both operands arrive, issues one per cycle.
// Optional macro RS_AGE_SELECT_EN: issue the oldest ready entry (age matrix) instead of lowest index.
module reservation_station #(
  parameter int unsigned            RS_WIDTH     = 3,
  parameter int unsigned            RoB_WIDTH    = 8,
  parameter int unsigned            EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP     = 9'b100000000,
  parameter int unsigned            ADDR_WIDTH   = 32
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRS_en,
  input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
  input  logic [31:0]             DPRS_Vj,
  input  logic [31:0]             DPRS_Vk,
  input  logic [31:0]             DPRS_imm,
  input  logic [6:0]              DPRS_opcode,
  input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
  output logic                    RSDP_full,
  input  logic                    CDBRS_RS_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
  input  logic [31:0]             CDBRS_RS_value,
  input  logic                    CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
  input  logic [31:0]             CDBRS_LSB_value,
  input  logic                    RoBRS_pre_judge,
  output logic                    RSALU_en,
  output logic [6:0]              RSALU_opcode,
  output logic [ADDR_WIDTH-1:0]   RSALU_pc,
  output logic [31:0]             RSALU_Vj,
  output logic [31:0]             RSALU_Vk,
  output logic [31:0]             RSALU_imm,
  output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);

  localparam int unsigned RS_SIZE = 1 << RS_WIDTH;

  logic [RS_SIZE-1:0]      r_busy;
  logic [ADDR_WIDTH-1:0]   r_pc  [RS_SIZE];
  logic [6:0]              r_op  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] r_qj  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] r_qk  [RS_SIZE];
  logic [31:0]             r_vj  [RS_SIZE];
  logic [31:0]             r_vk  [RS_SIZE];
  logic [31:0]             r_imm [RS_SIZE];
  logic [RoB_WIDTH-1:0]    r_rob [RS_SIZE];

  logic [RS_SIZE-1:0]      w_ready;
  logic                    w_issue_vld;
  logic [RS_WIDTH-1:0]     w_issue_idx;
  logic                    w_free_vld;
  logic [RS_WIDTH-1:0]     w_free_idx;
  logic [RS_WIDTH:0]       w_count;
  logic [EX_RoB_WIDTH-1:0] w_ins_qj;
  logic [EX_RoB_WIDTH-1:0] w_ins_qk;
  logic [31:0]             w_ins_vj;
  logic [31:0]             w_ins_vk;

`ifdef RS_AGE_SELECT_EN
  // r_age[i][j] set means entry i is older than entry j.
  logic [RS_SIZE-1:0] r_age   [RS_SIZE];
  logic [RS_SIZE-1:0] w_older [RS_SIZE];
`endif

  function automatic logic f_hit(input logic en, input logic [RoB_WIDTH-1:0] idx,
                                 input logic [EX_RoB_WIDTH-1:0] q);
    return en && (q == EX_RoB_WIDTH'({1'b0, idx}));
  endfunction

  always_comb begin
    w_ready    = '0;
    w_count    = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == NON_DEP) && (r_qk[i] == NON_DEP);
      w_count    = w_count + (RS_WIDTH + 1)'(r_busy[i]);
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = RS_WIDTH'(i);
      end
    end
  end

  assign RSDP_full = (w_count >= (RS_WIDTH + 1)'(RS_SIZE - 1));

  always_comb begin
    w_issue_vld = 1'b0;
    w_issue_idx = '0;
`ifdef RS_AGE_SELECT_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) w_older[i][j] = r_age[j][i];
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && ((w_ready & w_older[i]) == '0)) begin
        w_issue_vld = 1'b1;
        w_issue_idx = RS_WIDTH'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_issue_vld = 1'b1;
        w_issue_idx = RS_WIDTH'(i);
      end
    end
`endif
  end

  // Insert-time bypass; the RS bus has priority over the LSB bus.
  always_comb begin
    w_ins_qj = DPRS_Qj;
    w_ins_vj = DPRS_Vj;
    w_ins_qk = DPRS_Qk;
    w_ins_vk = DPRS_Vk;
    if (f_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, DPRS_Qj)) begin
      w_ins_qj = NON_DEP;
      w_ins_vj = CDBRS_RS_value;
    end else if (f_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, DPRS_Qj)) begin
      w_ins_qj = NON_DEP;
      w_ins_vj = CDBRS_LSB_value;
    end
    if (f_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, DPRS_Qk)) begin
      w_ins_qk = NON_DEP;
      w_ins_vk = CDBRS_RS_value;
    end else if (f_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, DPRS_Qk)) begin
      w_ins_qk = NON_DEP;
      w_ins_vk = CDBRS_LSB_value;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      r_busy          <= '0;
      RSALU_en        <= 1'b0;
      RSALU_opcode    <= '0;
      RSALU_pc        <= '0;
      RSALU_Vj        <= '0;
      RSALU_Vk        <= '0;
      RSALU_imm       <= '0;
      RSALU_RoB_index <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
    end else if (!RoBRS_pre_judge) begin
      r_busy   <= '0;
      RSALU_en <= 1'b0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
    end else if (Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          if (f_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, r_qj[i])) begin
            r_qj[i] <= NON_DEP;
            r_vj[i] <= CDBRS_RS_value;
          end else if (f_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, r_qj[i])) begin
            r_qj[i] <= NON_DEP;
            r_vj[i] <= CDBRS_LSB_value;
          end
          if (f_hit(CDBRS_RS_en, CDBRS_RS_RoB_index, r_qk[i])) begin
            r_qk[i] <= NON_DEP;
            r_vk[i] <= CDBRS_RS_value;
          end else if (f_hit(CDBRS_LSB_en, CDBRS_LSB_RoB_index, r_qk[i])) begin
            r_qk[i] <= NON_DEP;
            r_vk[i] <= CDBRS_LSB_value;
          end
        end
      end

      RSALU_en <= w_issue_vld;
      if (w_issue_vld) begin
        r_busy[w_issue_idx] <= 1'b0;
        RSALU_opcode        <= r_op[w_issue_idx];
        RSALU_pc            <= r_pc[w_issue_idx];
        RSALU_Vj            <= r_vj[w_issue_idx];
        RSALU_Vk            <= r_vk[w_issue_idx];
        RSALU_imm           <= r_imm[w_issue_idx];
        RSALU_RoB_index     <= r_rob[w_issue_idx];
      end

      if (DPRS_en && w_free_vld) begin
        r_busy[w_free_idx] <= 1'b1;
        r_pc[w_free_idx]   <= DPRS_pc;
        r_op[w_free_idx]   <= DPRS_opcode;
        r_qj[w_free_idx]   <= w_ins_qj;
        r_qk[w_free_idx]   <= w_ins_qk;
        r_vj[w_free_idx]   <= w_ins_vj;
        r_vk[w_free_idx]   <= w_ins_vk;
        r_imm[w_free_idx]  <= DPRS_imm;
        r_rob[w_free_idx]  <= DPRS_RoB_index;
      end

`ifdef RS_AGE_SELECT_EN
      if (w_issue_vld) begin
        r_age[w_issue_idx] <= '0;
        for (int j = 0; j < RS_SIZE; j++) r_age[j][w_issue_idx] <= 1'b0;
      end
      // Every entry still busy after this edge is older than the newcomer.
      if (DPRS_en && w_free_vld) begin
        r_age[w_free_idx] <= '0;
        for (int j = 0; j < RS_SIZE; j++) begin
          r_age[j][w_free_idx] <= r_busy[j] && !(w_issue_vld && (w_issue_idx == RS_WIDTH'(j)));
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station; issued instructions are checked
// against a queue of expected results pushed when the stimulus is driven.
`timescale 1ns/1ps
module tb_reservation_station;

  localparam logic [8:0] ND = 9'b100000000;

  logic        clk = 1'b0;
  logic        rst, rdy, dp_en, full, cdb_rs_en, cdb_lsb_en, pre_judge;
  logic [31:0] dp_pc, dp_vj, dp_vk, dp_imm, cdb_rs_val, cdb_lsb_val;
  logic [8:0]  dp_qj, dp_qk;
  logic [6:0]  dp_op;
  logic [7:0]  dp_rob, cdb_rs_idx, cdb_lsb_idx;
  logic        alu_en;
  logic [6:0]  alu_op;
  logic [31:0] alu_pc, alu_vj, alu_vk, alu_imm;
  logic [7:0]  alu_rob;

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [7:0]  rob;
  } iss_t;

  iss_t exp_q[$];
  iss_t mon_o;
  int   n_pass = 0, n_fail = 0, n_total = 0;

  reservation_station dut (
    .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy),
    .DPRS_en(dp_en), .DPRS_pc(dp_pc), .DPRS_Qj(dp_qj), .DPRS_Qk(dp_qk),
    .DPRS_Vj(dp_vj), .DPRS_Vk(dp_vk), .DPRS_imm(dp_imm), .DPRS_opcode(dp_op),
    .DPRS_RoB_index(dp_rob), .RSDP_full(full),
    .CDBRS_RS_en(cdb_rs_en), .CDBRS_RS_RoB_index(cdb_rs_idx), .CDBRS_RS_value(cdb_rs_val),
    .CDBRS_LSB_en(cdb_lsb_en), .CDBRS_LSB_RoB_index(cdb_lsb_idx),
    .CDBRS_LSB_value(cdb_lsb_val), .RoBRS_pre_judge(pre_judge),
    .RSALU_en(alu_en), .RSALU_opcode(alu_op), .RSALU_pc(alu_pc), .RSALU_Vj(alu_vj),
    .RSALU_Vk(alu_vk), .RSALU_imm(alu_imm), .RSALU_RoB_index(alu_rob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_en(input string tag, input logic e);
    chk(tag, 160'(alu_en), 160'(e));
  endtask

  task automatic chk_full(input string tag, input logic e);
    chk(tag, 160'(full), 160'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] op, input logic [31:0] pc, input logic [8:0] qj,
                     input logic [31:0] vj, input logic [8:0] qk, input logic [31:0] vk,
                     input logic [31:0] imm, input logic [7:0] rob);
    dp_en = 1'b1; dp_op = op; dp_pc = pc; dp_qj = qj; dp_vj = vj;
    dp_qk = qk; dp_vk = vk; dp_imm = imm; dp_rob = rob;
  endtask

  task automatic expect_issue(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [31:0] imm,
                              input logic [7:0] rob);
    exp_q.push_back({op, pc, vj, vk, imm, rob});
  endtask

  task automatic rs_bus(input logic en, input logic [7:0] idx, input logic [31:0] val);
    cdb_rs_en = en; cdb_rs_idx = idx; cdb_rs_val = val;
  endtask

  task automatic lsb_bus(input logic en, input logic [7:0] idx, input logic [31:0] val);
    cdb_lsb_en = en; cdb_lsb_idx = idx; cdb_lsb_val = val;
  endtask

  // Every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (alu_en) begin
      mon_o = {alu_op, alu_pc, alu_vj, alu_vk, alu_imm, alu_rob};
      chk("issue_expected", 160'(exp_q.size() != 0), 160'(1));
      if (exp_q.size() != 0) chk("issue_fields", 160'(mon_o), 160'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; pre_judge = 1'b1; dp_en = 1'b0;
    dp_op = '0; dp_pc = '0; dp_qj = ND; dp_qk = ND; dp_vj = '0; dp_vk = '0;
    dp_imm = '0; dp_rob = '0;
    rs_bus(1'b0, 8'd0, 32'd0);
    lsb_bus(1'b0, 8'd0, 32'd0);
    step(); step();
    chk_en("reset_en", 1'b0);
    chk_full("reset_full", 1'b0);
    chk("reset_vj", 160'(alu_vj), 160'(0));
    chk("reset_rob", 160'(alu_rob), 160'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_en("idle_en", 1'b0);
      chk_full("idle_full", 1'b0);
    end

    // Ready addi: issue pulse in the cycle after the second edge.
    ins(7'd20, 32'h100, ND, 32'd5, ND, 32'd0, 32'd3, 8'd2);
    expect_issue(7'd20, 32'h100, 32'd5, 32'd0, 32'd3, 8'd2);
    step(); dp_en = 1'b0;
    chk_en("addi_not_yet", 1'b0);
    step(); chk_en("addi_issue", 1'b1);
    step(); chk_en("addi_pulse_end", 1'b0);

    // Wakeup from the LSB bus, one cycle after the insert.
    ins(7'd21, 32'h104, {1'b0, 8'd7}, 32'hDEAD, ND, 32'd1, 32'd0, 8'd3);
    expect_issue(7'd21, 32'h104, 32'h10, 32'd1, 32'd0, 8'd3);
    step(); dp_en = 1'b0;
    lsb_bus(1'b1, 8'd7, 32'h10);
    step(); lsb_bus(1'b0, 8'd0, 32'd0);
    chk_en("wake_no_same_edge", 1'b0);
    step(); chk_en("wake_issue", 1'b1);

    // Broadcast coinciding with insert: bypass.
    ins(7'd21, 32'h108, {1'b0, 8'd7}, 32'hDEAD, ND, 32'd1, 32'd0, 8'd4);
    lsb_bus(1'b1, 8'd7, 32'h20);
    expect_issue(7'd21, 32'h108, 32'h20, 32'd1, 32'd0, 8'd4);
    step(); dp_en = 1'b0; lsb_bus(1'b0, 8'd0, 32'd0);
    chk_en("bypass_not_yet", 1'b0);
    step(); chk_en("bypass_issue", 1'b1);

    // Both tags match both buses at insert: RS bus wins for each.
    ins(7'd24, 32'h10C, {1'b0, 8'd8}, 32'd0, {1'b0, 8'd8}, 32'd0, 32'd9, 8'd5);
    rs_bus(1'b1, 8'd8, 32'hAA);
    lsb_bus(1'b1, 8'd8, 32'hBB);
    expect_issue(7'd24, 32'h10C, 32'hAA, 32'hAA, 32'd9, 8'd5);
    step(); dp_en = 1'b0; rs_bus(1'b0, 8'd0, 32'd0); lsb_bus(1'b0, 8'd0, 32'd0);
    step(); chk_en("prio_issue", 1'b1);

    // Qj and Qk wake from different buses on the same edge.
    ins(7'd25, 32'h110, {1'b0, 8'd11}, 32'd0, {1'b0, 8'd12}, 32'd0, 32'd0, 8'd6);
    expect_issue(7'd25, 32'h110, 32'd1, 32'd2, 32'd0, 8'd6);
    step(); dp_en = 1'b0;
    rs_bus(1'b1, 8'd11, 32'd1);
    lsb_bus(1'b1, 8'd12, 32'd2);
    step(); rs_bus(1'b0, 8'd0, 32'd0); lsb_bus(1'b0, 8'd0, 32'd0);
    step(); chk_en("dual_wake_issue", 1'b1);
    step(); chk_en("dual_wake_end", 1'b0);

    // Fill seven entries waiting on tag 9.
    for (int i = 0; i < 7; i++) begin
      ins(7'd22, 32'h200 + 32'(i * 4), {1'b0, 8'd9}, 32'd0, ND, 32'(i), 32'(i + 100),
          8'(10 + i));
      expect_issue(7'd22, 32'h200 + 32'(i * 4), 32'h99, 32'(i), 32'(i + 100), 8'(10 + i));
      step();
      if (i == 5) chk_full("six_not_full", 1'b0);
    end
    dp_en = 1'b0;
    chk_full("seven_full", 1'b1);
    rs_bus(1'b1, 8'd9, 32'h99);
    step(); rs_bus(1'b0, 8'd0, 32'd0);
    chk_en("fill_wake_no_issue", 1'b0);
    chk_full("fill_still_full", 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_en("fill_burst", 1'b1);
    end
    step();
    chk_en("fill_burst_end", 1'b0);
    chk_full("fill_drained", 1'b0);

    // Stall holds a ready entry until Sys_rdy returns.
    ins(7'd26, 32'h300, ND, 32'd7, ND, 32'd8, 32'd9, 8'd30);
    expect_issue(7'd26, 32'h300, 32'd7, 32'd8, 32'd9, 8'd30);
    step(); dp_en = 1'b0; rdy = 1'b0;
    step(); chk_en("stall_hold1", 1'b0);
    step(); chk_en("stall_hold2", 1'b0);
    rdy = 1'b1;
    step(); chk_en("stall_release", 1'b1);
    step(); chk_en("stall_end", 1'b0);

    // Flush on the edge that would issue: nothing issues.
    ins(7'd27, 32'h400, ND, 32'd1, ND, 32'd1, 32'd1, 8'd40);
    step(); dp_en = 1'b0; pre_judge = 1'b0;
    step(); pre_judge = 1'b1;
    chk_en("flush_kills_issue", 1'b0);
    step(); chk_en("flush_kills_issue2", 1'b0);

    // Six busy entries, flush with concurrent insert.
    for (int i = 0; i < 6; i++) begin
      ins(7'd28, 32'h500 + 32'(i * 4), {1'b0, 8'd13}, 32'd0, ND, 32'd0, 32'd0, 8'(41 + i));
      step();
    end
    chk_full("flush_six_busy", 1'b0);
    ins(7'd29, 32'h600, ND, 32'd3, ND, 32'd3, 32'd3, 8'd50);
    pre_judge = 1'b0;
    step(); dp_en = 1'b0; pre_judge = 1'b1;
    chk_en("flush_en", 1'b0);
    chk_full("flush_full", 1'b0);
    rs_bus(1'b1, 8'd13, 32'd1);
    step(); rs_bus(1'b0, 8'd0, 32'd0);
    step(); chk_en("flush_no_stale1", 1'b0);
    step(); chk_en("flush_no_stale2", 1'b0);

    // Selection order: A (tag 4) in entry 0, B (tag 5) in entry 1, C (tag 5) reuses entry 0.
    ins(7'd30, 32'h700, {1'b0, 8'd4}, 32'd0, ND, 32'd0, 32'd0, 8'd60);
    step();
    ins(7'd31, 32'h704, {1'b0, 8'd5}, 32'd0, ND, 32'd0, 32'd0, 8'd61);
    step(); dp_en = 1'b0;
    rs_bus(1'b1, 8'd4, 32'h44);
    expect_issue(7'd30, 32'h700, 32'h44, 32'd0, 32'd0, 8'd60);
    step(); rs_bus(1'b0, 8'd0, 32'd0);
    step(); chk_en("age_a_issue", 1'b1);
    ins(7'd32, 32'h708, {1'b0, 8'd5}, 32'd0, ND, 32'd0, 32'd0, 8'd62);
    step(); dp_en = 1'b0;
    chk_en("age_c_insert", 1'b0);
    lsb_bus(1'b1, 8'd5, 32'h55);
`ifdef RS_AGE_SELECT_EN
    expect_issue(7'd31, 32'h704, 32'h55, 32'd0, 32'd0, 8'd61);
    expect_issue(7'd32, 32'h708, 32'h55, 32'd0, 32'd0, 8'd62);
`else
    expect_issue(7'd32, 32'h708, 32'h55, 32'd0, 32'd0, 8'd62);
    expect_issue(7'd31, 32'h704, 32'h55, 32'd0, 32'd0, 8'd61);
`endif
    step(); lsb_bus(1'b0, 8'd0, 32'd0);
    step(); chk_en("age_first", 1'b1);
    step(); chk_en("age_second", 1'b1);
    step(); chk_en("age_end", 1'b0);
    chk("queue_drained", 160'(exp_q.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
